// File: rtl/slowctrl_cmd_queue.sv
`default_nettype none
// slowctrl_cmd_queue: command FIFO that issues one register write at a time to a
// downstream serial controller, with sticky overflow and busy-timeout flags.
module slowctrl_cmd_queue #(
    parameter int DEPTH    = 16,
    parameter int BUSY_TMO = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     cmd_wstb_i,
    input  logic [9:0]               cmd_adr_i,
    input  logic [31:0]              cmd_dat_i,
    output logic                     cmd_full_o,
    output logic [$clog2(DEPTH):0]   cmd_level_o,
    output logic                     ovf_o,
    output logic                     tmo_o,
    input  logic                     flag_clr_i,
    output logic                     wr_req_o,
    output logic [9:0]               wr_adr_o,
    output logic [31:0]              wr_dat_o,
    input  logic                     busy_i,
    output logic                     idle_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(BUSY_TMO + 1);
    localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] TMO_LAST   = CW'(BUSY_TMO - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_IDLE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [41:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic [AW:0]   level_nxt;
    logic [CW-1:0] tmo_cnt;
    logic          push;
    logic          pop;
    logic          tmo_hit;

    assign cmd_full_o  = (level == FULL_LEVEL);
    assign cmd_level_o = level;
    assign wr_req_o    = (state == ISSUE);

    // A push is judged against the pre-edge fullness, so a same-cycle pop never rescues it.
    assign push    = cmd_wstb_i && !cmd_full_o;
    assign pop     = (state == IDLE) && (level != '0) && !busy_i;
    assign tmo_hit = (state == WAIT_BUSY) && !busy_i && (tmo_cnt == TMO_LAST);

    always_comb begin
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + (AW + 1)'(1);
            2'b01:   level_nxt = level - (AW + 1)'(1);
            default: level_nxt = level;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (pop) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (busy_i || tmo_hit) state_nxt = WAIT_IDLE;
            WAIT_IDLE: if (!busy_i) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            tmo_cnt  <= '0;
            wr_adr_o <= '0;
            wr_dat_o <= '0;
            ovf_o    <= 1'b0;
            tmo_o    <= 1'b0;
            idle_o   <= 1'b1;
        end else begin
            state  <= state_nxt;
            level  <= level_nxt;
            idle_o <= (level_nxt == '0) && (state_nxt == IDLE);
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr                 <= rd_ptr + AW'(1);
                {wr_adr_o, wr_dat_o}   <= mem[rd_ptr];
            end
            if (state == WAIT_BUSY) begin
                tmo_cnt <= tmo_cnt + CW'(1);
            end else begin
                tmo_cnt <= '0;
            end
            // Setting a flag takes priority over clearing it in the same cycle.
            if (cmd_wstb_i && cmd_full_o) begin
                ovf_o <= 1'b1;
            end else if (flag_clr_i) begin
                ovf_o <= 1'b0;
            end
            if (tmo_hit) begin
                tmo_o <= 1'b1;
            end else if (flag_clr_i) begin
                tmo_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_adr_i, cmd_dat_i};
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_slowctrl_cmd_queue.sv
`default_nettype none
// Bench for slowctrl_cmd_queue: queue-based behavioural model compared every cycle,
// directed scenarios with literal expectations, and randomized traffic.
module tb_slowctrl_cmd_queue;
    localparam int DEPTH    = 16;
    localparam int BUSY_TMO = 8;
    localparam int LW       = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_wstb = 1'b0;
    logic [9:0]    cmd_adr = '0;
    logic [31:0]   cmd_dat = '0;
    logic          flag_clr = 1'b0;
    logic          busy;
    logic          cmd_full;
    logic [LW-1:0] cmd_level;
    logic          ovf;
    logic          tmo;
    logic          wr_req;
    logic [9:0]    wr_adr;
    logic [31:0]   wr_dat;
    logic          idle;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    slowctrl_cmd_queue #(.DEPTH(DEPTH), .BUSY_TMO(BUSY_TMO)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .cmd_wstb_i(cmd_wstb), .cmd_adr_i(cmd_adr),
        .cmd_dat_i(cmd_dat), .cmd_full_o(cmd_full), .cmd_level_o(cmd_level), .ovf_o(ovf),
        .tmo_o(tmo), .flag_clr_i(flag_clr), .wr_req_o(wr_req), .wr_adr_o(wr_adr),
        .wr_dat_o(wr_dat), .busy_i(busy), .idle_o(idle)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Downstream controller: forced level, 100-cycle responder, or random runs.
    int   busy_mode = 0;
    logic busy_force = 1'b0;
    logic busy_auto = 1'b0;
    int   busy_left = 0;
    assign busy = (busy_mode == 0) ? busy_force : busy_auto;

    always @(negedge clk) begin
        if (busy_mode == 1) begin
            if (wr_req === 1'b1) begin
                busy_auto <= 1'b1;
                busy_left <= 99;
            end else if (busy_left > 0) begin
                busy_auto <= 1'b1;
                busy_left <= busy_left - 1;
            end else begin
                busy_auto <= 1'b0;
            end
        end else if (busy_mode == 2) begin
            if ($urandom_range(0, 7) == 0) busy_auto <= ~busy_auto;
        end else begin
            busy_auto <= 1'b0;
            busy_left <= 0;
        end
    end

    // Behavioural model: a queue of pending commands and the phase of the one in flight.
    typedef enum {M_FREE, M_REQ, M_AWAIT_BUSY, M_AWAIT_RELEASE} mphase_t;
    logic [41:0] mq[$];
    mphase_t     mph = M_FREE;
    int          waited = 0;
    logic [9:0]  m_adr = '0;
    logic [31:0] m_dat = '0;
    logic        m_ovf = 1'b0;
    logic        m_tmo = 1'b0;
    bit          model_live = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            mq.delete();
            mph        <= M_FREE;
            waited     <= 0;
            m_adr      <= '0;
            m_dat      <= '0;
            m_ovf      <= 1'b0;
            m_tmo      <= 1'b0;
            model_live <= 1'b1;
        end else begin : model_step
            automatic bit take      = (mph == M_FREE) && (mq.size() > 0) && !busy;
            automatic bit was_full  = (mq.size() == DEPTH);
            automatic bit timed_out = (mph == M_AWAIT_BUSY) && !busy && (waited + 1 >= BUSY_TMO);
            if (take) {m_adr, m_dat} <= mq.pop_front();
            if (cmd_wstb && !was_full) mq.push_back({cmd_adr, cmd_dat});
            case (mph)
                M_FREE:       if (take) mph <= M_REQ;
                M_REQ:        begin mph <= M_AWAIT_BUSY; waited <= 0; end
                M_AWAIT_BUSY: begin
                    if (busy || timed_out) mph <= M_AWAIT_RELEASE;
                    else waited <= waited + 1;
                end
                default:      if (!busy) mph <= M_FREE;
            endcase
            m_ovf <= (cmd_wstb && was_full) || (m_ovf && !flag_clr);
            m_tmo <= timed_out || (m_tmo && !flag_clr);
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("level", 64'(cmd_level), 64'(mq.size()));
            check("full", 64'(cmd_full), 64'(mq.size() == DEPTH));
            check("wr_req", 64'(wr_req), 64'(mph == M_REQ));
            check("wr_adr", 64'(wr_adr), 64'(m_adr));
            check("wr_dat", 64'(wr_dat), 64'(m_dat));
            check("ovf", 64'(ovf), 64'(m_ovf));
            check("tmo", 64'(tmo), 64'(m_tmo));
            check("idle", 64'(idle), 64'((mq.size() == 0) && (mph == M_FREE)));
        end
    end

    logic [9:0] issued[$];
    always @(negedge clk) begin
        if (reset_n && wr_req === 1'b1) issued.push_back(wr_adr);
    end

    task automatic drive(input bit w, input logic [9:0] a, input logic [31:0] d, input bit clr);
        cmd_wstb = w;
        cmd_adr  = a;
        cmd_dat  = d;
        flag_clr = clr;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (idle !== 1'b1 && n < limit) begin
            drive(1'b0, '0, '0, 1'b0);
            n++;
        end
        check("wait_idle_bound", 64'(idle), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  t_first;
        int  t_second;
        int  pushes;
        int  guard;
        int  reqs;
        bit  w;
        bit  found;

        repeat (3) @(negedge clk);
        check("rst_level", 64'(cmd_level), 64'(0));
        check("rst_full", 64'(cmd_full), 64'(0));
        check("rst_wr_req", 64'(wr_req), 64'(0));
        check("rst_wr_adr", 64'(wr_adr), 64'(0));
        check("rst_wr_dat", 64'(wr_dat), 64'(0));
        check("rst_flags", 64'({ovf, tmo}), 64'(0));
        check("rst_idle", 64'(idle), 64'(1));
        reset_n = 1'b1;

        // Single write, then busy never rises so the timeout path runs.
        drive(1'b1, 10'h3AA, 32'h55AA55AA, 1'b0);
        check("single_level_after_push", 64'(cmd_level), 64'(1));
        check("single_no_req_yet", 64'(wr_req), 64'(0));
        drive(1'b0, '0, '0, 1'b0);
        check("single_req", 64'(wr_req), 64'(1));
        check("single_adr", 64'(wr_adr), 64'(10'h3AA));
        check("single_dat", 64'(wr_dat), 64'(32'h55AA55AA));
        check("single_level_zero", 64'(cmd_level), 64'(0));
        drive(1'b0, '0, '0, 1'b0);
        check("single_req_one_cycle", 64'(wr_req), 64'(0));
        repeat (BUSY_TMO - 1) drive(1'b0, '0, '0, 1'b0);
        check("tmo_not_early", 64'(tmo), 64'(0));
        drive(1'b0, '0, '0, 1'b0);
        check("tmo_set", 64'(tmo), 64'(1));
        check("tmo_not_idle_yet", 64'(idle), 64'(0));
        drive(1'b0, '0, '0, 1'b0);
        check("tmo_back_to_idle", 64'(idle), 64'(1));
        drive(1'b0, '0, '0, 1'b1);
        check("tmo_cleared", 64'(tmo), 64'(0));

        // Back-to-back pushes with a downstream that stays busy 100 cycles per request.
        busy_mode = 1;
        drive(1'b1, 10'h3AA, 32'h55AA55AA, 1'b0);
        drive(1'b1, 10'h355, 32'hAA55AA55, 1'b0);
        t_first  = -1;
        t_second = -1;
        for (int c = 0; c < 400 && t_second < 0; c++) begin
            if (wr_req === 1'b1) begin
                if (t_first < 0) begin
                    t_first = c;
                    check("b2b_first_adr", 64'(wr_adr), 64'(10'h3AA));
                    check("b2b_first_dat", 64'(wr_dat), 64'(32'h55AA55AA));
                end else begin
                    t_second = c;
                    check("b2b_second_adr", 64'(wr_adr), 64'(10'h355));
                    check("b2b_second_dat", 64'(wr_dat), 64'(32'hAA55AA55));
                end
            end
            if (t_second < 0) drive(1'b0, '0, '0, 1'b0);
        end
        check("b2b_second_issued", 64'(t_second >= 0), 64'(1));
        check("b2b_waits_busy_fall", 64'((t_second - t_first) > 100), 64'(1));
        wait_idle(400);

        // Overflow: downstream held busy, DEPTH+1 pushes.
        busy_mode  = 0;
        busy_force = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            drive(1'b1, (i == DEPTH) ? 10'h3FF : 10'(10'h100 + i), 32'hC0DE0000 + 32'(i), 1'b0);
            if (i == DEPTH - 1) begin
                check("ovf_full_at_depth", 64'(cmd_full), 64'(1));
                check("ovf_not_yet", 64'(ovf), 64'(0));
            end
        end
        check("ovf_full", 64'(cmd_full), 64'(1));
        check("ovf_level", 64'(cmd_level), 64'(16));
        check("ovf_flag", 64'(ovf), 64'(1));
        drive(1'b0, '0, '0, 1'b1);
        check("ovf_cleared", 64'(ovf), 64'(0));
        issued.delete();
        busy_force = 1'b0;
        wait_idle(600);
        check("ovf_issue_count", 64'(issued.size()), 64'(DEPTH));
        found = 1'b0;
        foreach (issued[k]) if (issued[k] == 10'h3FF) found = 1'b1;
        check("ovf_dropped_never_issued", 64'(found), 64'(0));
        drive(1'b0, '0, '0, 1'b1);

        // Wrap and concurrency: simultaneous push/pop at level 5, then interleaved traffic.
        busy_force = 1'b1;
        for (int i = 0; i < 5; i++) drive(1'b1, 10'(10'h200 + i), $urandom, 1'b0);
        check("wrap_level5", 64'(cmd_level), 64'(5));
        busy_force = 1'b0;
        drive(1'b1, 10'h205, $urandom, 1'b0);
        check("wrap_level_held", 64'(cmd_level), 64'(5));
        check("wrap_issue", 64'(wr_req), 64'(1));
        check("wrap_first_adr", 64'(wr_adr), 64'(10'h200));
        pushes    = 6;
        guard     = 0;
        busy_mode = 2;
        while (pushes < 40 && guard < 3000) begin
            w = 1'($urandom_range(0, 1));
            if (w && !cmd_full) pushes++;
            drive(w, 10'($urandom), $urandom, 1'b0);
            guard++;
        end
        check("wrap_pushes_done", 64'(pushes), 64'(40));
        busy_mode = 0;
        wait_idle(1000);

        // Randomized soak with occasional flag clears.
        busy_mode = 2;
        for (int c = 0; c < 600; c++) begin
            drive(1'($urandom_range(0, 1)), 10'($urandom), $urandom, $urandom_range(0, 19) == 0);
        end
        busy_mode = 0;
        wait_idle(1000);
        drive(1'b0, '0, '0, 1'b1);

        // Reset while waiting for the controller to go idle with 3 commands queued.
        busy_mode = 1;
        for (int i = 0; i < 4; i++) drive(1'b1, 10'(10'h2A0 + i), $urandom, 1'b0);
        repeat (5) drive(1'b0, '0, '0, 1'b0);
        check("rst_mid_level3", 64'(cmd_level), 64'(3));
        check("rst_mid_busy_phase", 64'({wr_req, idle}), 64'(0));
        #2 reset_n = 1'b0;
        busy_mode = 0;
        #1;
        check("rst_mid_req_low", 64'(wr_req), 64'(0));
        check("rst_mid_level0", 64'(cmd_level), 64'(0));
        check("rst_mid_idle", 64'(idle), 64'(1));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        reqs = 0;
        for (int c = 0; c < 30; c++) begin
            drive(1'b0, '0, '0, 1'b0);
            if (wr_req === 1'b1) reqs++;
        end
        check("rst_mid_no_req", 64'(reqs), 64'(0));
        check("rst_mid_idle_after", 64'(idle), 64'(1));
        drive(1'b1, 10'h1C3, 32'h0BADF00D, 1'b0);
        check("resume_level", 64'(cmd_level), 64'(1));
        drive(1'b0, '0, '0, 1'b0);
        check("resume_req", 64'(wr_req), 64'(1));
        check("resume_adr", 64'(wr_adr), 64'(10'h1C3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
